sia_receiver_fifo: RTL and testbench

SIA_RECEIVER_FIFO -- requirements
Module: sia_receiver_fifo

---
 rtl/sia_receiver_fifo_if.sv | 11 +
 rtl/sia_receiver_fifo.sv | 237 +++++++++++++++++++++++
 tb/tb_sia_receiver_fifo.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sia_receiver_fifo_if.sv
// rtl/sia_receiver_fifo_if.sv - receive FIFO pop-side handshake bundle
interface sia_receiver_fifo_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] dat_o;
  logic             valid_o;
  logic             ack_i;

  modport master (output dat_o, output valid_o, input ack_i);
  modport slave  (input dat_o, input valid_o, output ack_i);
endinterface

// File: rtl/sia_receiver_fifo.sv
// rtl/sia_receiver_fifo.sv - serial receiver with frame FIFO; optional break detect via SIA_RX_BREAK_DETECT_EN
module sia_receiver_fifo #(
  parameter int SHIFT_REG_WIDTH = 64,
  parameter int BAUD_RATE_WIDTH = 32,
  parameter int BITS_WIDTH      = 6,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [BITS_WIDTH-1:0]      bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       eedd_i,
  input  logic                       eedc_i,
  input  logic                       rxd_i,
  input  logic                       rxc_i,
  input  logic                       clr_overrun_i,
  sia_receiver_fifo_if.master        rx_if,
  output logic                       overrun_o,
  output logic                       idle_o,
  output logic                       sample_to,
  output logic                       break_o
);
  localparam int W     = SHIFT_REG_WIDTH;
  localparam int CW    = $clog2(W + 1);
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int NW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

`ifdef SIA_RX_BREAK_DETECT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RECV = 2'd1, ST_BRKWAIT = 2'd2} state_t;
  logic break_q, break_d;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RECV = 2'd1} state_t;
`endif

  state_t                     state_q, state_d;
  logic [W-1:0]               shift_q, shift_d, shift_next, push_data;
  logic [CW-1:0]              bit_cnt_q, bit_cnt_d, cnt_next, bits_lat_q, bits_lat_d, bits_eff, bits_target;
  logic [BAUD_RATE_WIDTH-1:0] baud_cnt_q, baud_cnt_d, baud_lat_q, baud_lat_d;
  logic                       eedd_lat_q, eedd_lat_d;
  logic                       rxd_s1_q, rxd_s2_q, rxd_prev_q, rxd_s1_d, rxd_s2_d, rxd_prev_d;
  logic                       rxc_s1_q, rxc_s2_q, rxc_prev_q, rxc_s1_d, rxc_s2_d, rxc_prev_d;
  logic                       sample_to_q, sample_to_d;
  logic                       sample_now, push_req, rxd_edge, rxc_rise;
  logic [W-1:0]               fifo_mem [DEPTH];
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]              count_q, count_d;
  logic                       overrun_q, overrun_d;
  logic                       pop, full, push_ok, drop;

  assign rxd_edge = rxd_s2_q != rxd_prev_q;
  assign rxc_rise = rxc_s2_q & ~rxc_prev_q;

  // Frame length as latched at frame start: zero means one bit, anything above W clamps to W.
  always_comb begin
    bits_eff = CW'(bits_i);
    if (bits_i == '0) bits_eff = CW'(1);
    else if (int'(bits_i) > W) bits_eff = CW'(W);
  end

  // Receive sequencing: start detection, bit timing, shifting and frame completion.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    baud_cnt_d  = baud_cnt_q;
    bits_lat_d  = bits_lat_q;
    baud_lat_d  = baud_lat_q;
    eedd_lat_d  = eedd_lat_q;
    sample_now  = 1'b0;
    push_req    = 1'b0;
    push_data   = shift_q;
    shift_next  = shift_q;
    cnt_next    = bit_cnt_q;
    bits_target = bits_lat_q;
    rxd_s1_d    = rxd_i;
    rxd_s2_d    = rxd_s1_q;
    rxd_prev_d  = rxd_s2_q;
    rxc_s1_d    = rxc_i;
    rxc_s2_d    = rxc_s1_q;
    rxc_prev_d  = rxc_s2_q;
`ifdef SIA_RX_BREAK_DETECT_EN
    break_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        shift_d     = '1;
        bit_cnt_d   = '0;
        bits_target = bits_eff;
        if (eedc_i) begin
          // The clock edge that starts the frame is also its first sample.
          if (rxc_rise) begin
            state_d    = ST_RECV;
            bits_lat_d = bits_eff;
            baud_lat_d = baud_i;
            eedd_lat_d = eedd_i;
            sample_now = 1'b1;
          end
        end else if (!rxd_s2_q) begin
          // Half a bit period puts every later sample near mid-bit.
          state_d    = ST_RECV;
          bits_lat_d = bits_eff;
          baud_lat_d = baud_i;
          eedd_lat_d = eedd_i;
          baud_cnt_d = baud_i >> 1;
        end
      end
      ST_RECV: begin
        if (eedc_i) begin
          sample_now = rxc_rise;
        end else if (eedd_lat_q && rxd_edge) begin
          baud_cnt_d = baud_lat_q >> 1;
        end else if (baud_cnt_q == '0) begin
          sample_now = 1'b1;
          baud_cnt_d = baud_lat_q;
        end else begin
          baud_cnt_d = baud_cnt_q - BAUD_RATE_WIDTH'(1);
        end
      end
`ifdef SIA_RX_BREAK_DETECT_EN
      ST_BRKWAIT: begin
        shift_d   = '1;
        bit_cnt_d = '0;
        if (rxd_s2_q) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (sample_now) begin
      shift_next = {rxd_s2_q, shift_q[W-1:1]};
      cnt_next   = bit_cnt_q + CW'(1);
      if (cnt_next >= bits_target) begin
        state_d   = ST_IDLE;
        shift_d   = '1;
        bit_cnt_d = '0;
        push_data = shift_next;
`ifdef SIA_RX_BREAK_DETECT_EN
        // Unsampled positions stay one, so an all-zero frame equals ones shifted right by its length.
        if (shift_next == ({W{1'b1}} >> bits_target)) begin
          break_d = 1'b1;
          state_d = ST_BRKWAIT;
        end else begin
          push_req = 1'b1;
        end
`else
        push_req = 1'b1;
`endif
      end else begin
        shift_d   = shift_next;
        bit_cnt_d = cnt_next;
      end
    end
    sample_to_d = sample_now;
  end

  // FIFO bookkeeping: a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    pop       = rx_if.ack_i && (count_q != '0);
    full      = count_q == NW'(DEPTH);
    push_ok   = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    wr_ptr_d  = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (push_ok && !pop) count_d = count_q + NW'(1);
    else if (!push_ok && pop) count_d = count_q - NW'(1);
    overrun_d = overrun_q;
    if (drop) overrun_d = 1'b1;
    else if (clr_overrun_i) overrun_d = 1'b0;
  end

  // State, synchroniser and FIFO pointer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      shift_q     <= '1;
      bit_cnt_q   <= '0;
      baud_cnt_q  <= '0;
      bits_lat_q  <= '0;
      baud_lat_q  <= '0;
      eedd_lat_q  <= 1'b0;
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_prev_q  <= 1'b1;
      rxc_s1_q    <= 1'b0;
      rxc_s2_q    <= 1'b0;
      rxc_prev_q  <= 1'b0;
      sample_to_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
`ifdef SIA_RX_BREAK_DETECT_EN
      break_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      baud_cnt_q  <= baud_cnt_d;
      bits_lat_q  <= bits_lat_d;
      baud_lat_q  <= baud_lat_d;
      eedd_lat_q  <= eedd_lat_d;
      rxd_s1_q    <= rxd_s1_d;
      rxd_s2_q    <= rxd_s2_d;
      rxd_prev_q  <= rxd_prev_d;
      rxc_s1_q    <= rxc_s1_d;
      rxc_s2_q    <= rxc_s2_d;
      rxc_prev_q  <= rxc_prev_d;
      sample_to_q <= sample_to_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
`ifdef SIA_RX_BREAK_DETECT_EN
      break_q     <= break_d;
`endif
    end
  end

  // Frame storage; contents are only visible through the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_data;
  end

  assign rx_if.valid_o = count_q != '0;
  assign rx_if.dat_o   = (count_q != '0) ? fifo_mem[rd_ptr_q] : '1;
  assign overrun_o     = overrun_q;
  assign idle_o        = state_q == ST_IDLE;
  assign sample_to     = sample_to_q;
`ifdef SIA_RX_BREAK_DETECT_EN
  assign break_o       = break_q;
`else
  assign break_o       = 1'b0;
`endif
endmodule

// File: tb/tb_sia_receiver_fifo.sv
// tb/tb_sia_receiver_fifo.sv - randomized self-checking bench for sia_receiver_fifo
module tb_sia_receiver_fifo;
  localparam int W = 64;

  logic        clk = 1'b0;
  logic        reset_i, eedd_i, eedc_i, rxd_i, rxc_i, clr_overrun_i;
  logic [5:0]  bits_i;
  logic [31:0] baud_i;
  logic        overrun_o, idle_o, sample_to, break_o;

  int errors = 0, checks = 0;
  int cyc = 0, samp_total = 0, brk_total = 0;
  int samp_times[$];
  logic [63:0] model_q[$];
  logic model_ovr;

  always #5 clk = ~clk;

  sia_receiver_fifo_if #(.WIDTH(W)) rx_if ();

  sia_receiver_fifo #(
    .SHIFT_REG_WIDTH(W), .BAUD_RATE_WIDTH(32), .BITS_WIDTH(6), .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .bits_i(bits_i), .baud_i(baud_i),
    .eedd_i(eedd_i), .eedc_i(eedc_i), .rxd_i(rxd_i), .rxc_i(rxc_i),
    .clr_overrun_i(clr_overrun_i), .rx_if(rx_if), .overrun_o(overrun_o),
    .idle_o(idle_o), .sample_to(sample_to), .break_o(break_o)
  );

  always @(negedge clk) begin
    cyc++;
    if (sample_to === 1'b1) begin samp_total++; samp_times.push_back(cyc); end
    if (break_o === 1'b1) brk_total++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // Expected frame: the n received bits occupy the top n positions, first bit lowest; the rest stay one.
  function automatic logic [63:0] exp_frame(input logic [63:0] v, input int n);
    logic [63:0] f;
    int m;
    m = (n < 1) ? 1 : ((n > W) ? W : n);
    f = '1;
    for (int i = 0; i < m; i++) f[W - m + i] = v[i];
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i = 1'b1; rxd_i = 1'b1; rxc_i = 1'b0; eedc_i = 1'b0; eedd_i = 1'b0;
    clr_overrun_i = 1'b0; rx_if.ack_i = 1'b0; bits_i = 6'd11; baud_i = 32'd9;
    tick(3);
    reset_i = 1'b0;
    tick(2);
    model_q.delete();
    model_ovr = 1'b0;
  endtask

  task automatic pop_one();
    rx_if.ack_i = 1'b1; tick(1); rx_if.ack_i = 1'b0; tick(1);
  endtask

  // Drives one frame at the given bit period; configuration is scrambled after the first bit.
  task automatic send_frame(input logic [63:0] v, input int n, input int baud, input logic eedd);
    bits_i = 6'(n); baud_i = 32'(baud); eedd_i = eedd;
    for (int i = 0; i < n; i++) begin
      rxd_i = v[i];
      tick(baud + 1);
      if (i == 0) begin bits_i = 6'($urandom); baud_i = $urandom; eedd_i = 1'($urandom_range(0, 1)); end
    end
    rxd_i = 1'b1;
    tick(baud + 1);
  endtask

  // Raises ack for exactly the clock edge on which the last sample of an n-bit frame lands.
  task automatic ack_at_last(input int n, input int baud);
    int seen = 0, guard = 0;
    while (seen < n - 1 && guard < 20000) begin
      tick(1); guard++;
      if (sample_to === 1'b1) seen++;
    end
    checks++; if (seen < n - 1) begin errors++; $display("FAIL ack_timing_wait: got %0d samples expected %0d", seen, n - 1); end
    tick(baud);
    rx_if.ack_i = 1'b1; tick(1); rx_if.ack_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle_o); end
    checks++; if (rx_if.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_if.valid_o); end
    checks++; if (rx_if.dat_o !== '1) begin errors++; $display("FAIL reset_dat: got %h expected all ones", rx_if.dat_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
    checks++; if (sample_to !== 1'b0) begin errors++; $display("FAIL reset_sample: got %b expected 0", sample_to); end
    checks++; if (break_o !== 1'b0) begin errors++; $display("FAIL reset_break: got %b expected 0", break_o); end
  endtask

  task automatic test_basic_frame();
    int s0, k0, bad;
    do_reset();
    s0 = samp_total; k0 = samp_times.size(); bad = 0;
    send_frame(64'h614, 11, 49, 1'b0);
    checks++; if (rx_if.valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rx_if.valid_o); end
    checks++; if (rx_if.dat_o !== {11'b11000010100, {53{1'b1}}}) begin errors++; $display("FAIL basic_dat: got %h expected %h", rx_if.dat_o, {11'b11000010100, {53{1'b1}}}); end
    checks++; if (samp_total - s0 != 11) begin errors++; $display("FAIL basic_sample_count: got %0d expected 11", samp_total - s0); end
    for (int i = k0 + 1; i < samp_times.size(); i++) if (samp_times[i] - samp_times[i-1] != 50) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_sample_spacing: got %0d gaps not 50 expected 0", bad); end
    pop_one();
    checks++; if (rx_if.valid_o !== 1'b0) begin errors++; $display("FAIL basic_pop_valid: got %b expected 0", rx_if.valid_o); end
  endtask

  task automatic test_random_frames();
    logic [63:0] v;
    int n, baud;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      baud = $urandom_range(5, 20); n = $urandom_range(2, 20);
      v = {$urandom, $urandom}; v[0] = 1'b0; v[n-1] = 1'b1;
      send_frame(v, n, baud, 1'($urandom_range(0, 1)));
      model_q.push_back(exp_frame(v, n));
      checks++; if (rx_if.valid_o !== 1'b1) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected 1", k, rx_if.valid_o); end
      checks++; if (rx_if.dat_o !== model_q[0]) begin errors++; $display("FAIL rand_dat[%0d]: got %h expected %h (n=%0d baud=%0d)", k, rx_if.dat_o, model_q[0], n, baud); end
      pop_one();
      void'(model_q.pop_front());
    end
    checks++; if (rx_if.valid_o !== 1'b0) begin errors++; $display("FAIL rand_empty: got %b expected 0", rx_if.valid_o); end
  endtask

  task automatic test_external();
    int s0, b0;
    do_reset();
    eedc_i = 1'b1; tick(1); rxd_i = 1'b0;
    s0 = samp_total; b0 = brk_total;
    for (int p = 1; p <= 11; p++) begin
      rxc_i = 1'b1; tick(4); rxc_i = 1'b0; tick(4);
      if (p < 11) begin
        checks++; if (idle_o !== 1'b0) begin errors++; $display("FAIL ext_idle[%0d]: got %b expected 0", p, idle_o); end
      end
    end
    checks++; if (samp_total - s0 != 11) begin errors++; $display("FAIL ext_samples: got %0d expected 11", samp_total - s0); end
`ifdef SIA_RX_BREAK_DETECT_EN
    checks++; if (brk_total - b0 != 1) begin errors++; $display("FAIL ext_break: got %0d expected 1", brk_total - b0); end
    checks++; if (rx_if.valid_o !== 1'b0) begin errors++; $display("FAIL ext_break_valid: got %b expected 0", rx_if.valid_o); end
    rxd_i = 1'b1; tick(5);
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL ext_break_idle: got %b expected 1", idle_o); end
`else
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL ext_idle_done: got %b expected 1", idle_o); end
    checks++; if (rx_if.valid_o !== 1'b1) begin errors++; $display("FAIL ext_valid: got %b expected 1", rx_if.valid_o); end
    checks++; if (rx_if.dat_o !== exp_frame(64'd0, 11)) begin errors++; $display("FAIL ext_dat: got %h expected %h", rx_if.dat_o, exp_frame(64'd0, 11)); end
    checks++; if (brk_total - b0 != 0) begin errors++; $display("FAIL ext_no_break: got %0d expected 0", brk_total - b0); end
`endif
    rxd_i = 1'b1; tick(2); eedc_i = 1'b0; tick(2);
  endtask

  task automatic test_overrun();
    logic [63:0] v;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      v = {$urandom, $urandom}; v[0] = 1'b0; v[10] = 1'b1;
      send_frame(v, 11, 9, 1'b0);
      if (model_q.size() < 4) model_q.push_back(exp_frame(v, 11)); else model_ovr = 1'b1;
    end
    checks++; if (overrun_o !== model_ovr) begin errors++; $display("FAIL ovr_flag: got %b expected %b", overrun_o, model_ovr); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rx_if.dat_o !== model_q[0] || rx_if.valid_o !== 1'b1) begin errors++; $display("FAIL ovr_pop[%0d]: got %h/%b expected %h/1", k, rx_if.dat_o, rx_if.valid_o, model_q[0]); end
      pop_one();
      void'(model_q.pop_front());
    end
    checks++; if (rx_if.valid_o !== 1'b0) begin errors++; $display("FAIL ovr_empty: got %b expected 0", rx_if.valid_o); end
    pop_one();
    v = {$urandom, $urandom}; v[0] = 1'b0; v[10] = 1'b1;
    send_frame(v, 11, 9, 1'b0);
    checks++; if (rx_if.dat_o !== exp_frame(v, 11)) begin errors++; $display("FAIL ovr_empty_ack: got %h expected %h", rx_if.dat_o, exp_frame(v, 11)); end
    pop_one();
    checks++; if (rx_if.valid_o !== 1'b0) begin errors++; $display("FAIL ovr_empty_ack_count: got %b expected 0", rx_if.valid_o); end
    clr_overrun_i = 1'b1; tick(1); clr_overrun_i = 1'b0; tick(1);
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun_o); end
  endtask

  task automatic test_full_push_pop();
    logic [63:0] v;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      v = {$urandom, $urandom}; v[0] = 1'b0; v[10] = 1'b1;
      send_frame(v, 11, 9, 1'b0);
      model_q.push_back(exp_frame(v, 11));
    end
    v = {$urandom, $urandom}; v[0] = 1'b0; v[10] = 1'b1;
    fork
      send_frame(v, 11, 9, 1'b0);
      ack_at_last(11, 9);
    join
    void'(model_q.pop_front());
    model_q.push_back(exp_frame(v, 11));
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL full_pp_overrun: got %b expected 0", overrun_o); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rx_if.dat_o !== model_q[0] || rx_if.valid_o !== 1'b1) begin errors++; $display("FAIL full_pp_pop[%0d]: got %h/%b expected %h/1", k, rx_if.dat_o, rx_if.valid_o, model_q[0]); end
      pop_one();
      void'(model_q.pop_front());
    end
    checks++; if (rx_if.valid_o !== 1'b0) begin errors++; $display("FAIL full_pp_empty: got %b expected 0", rx_if.valid_o); end
  endtask

  task automatic test_reset_midframe();
    int seen = 0, guard = 0;
    do_reset();
    rxd_i = 1'b0;
    while (seen < 5 && guard < 5000) begin
      tick(1); guard++;
      if (sample_to === 1'b1) seen++;
    end
    checks++; if (seen != 5) begin errors++; $display("FAIL midrst_wait: got %0d samples expected 5", seen); end
    reset_i = 1'b1; rxd_i = 1'b1; tick(2);
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b expected 1", idle_o); end
    checks++; if (rx_if.dat_o !== '1) begin errors++; $display("FAIL midrst_dat: got %h expected all ones", rx_if.dat_o); end
    reset_i = 1'b0; tick(200);
    checks++; if (rx_if.valid_o !== 1'b0) begin errors++; $display("FAIL midrst_no_push: got %b expected 0", rx_if.valid_o); end
  endtask

  task automatic test_zero_frame();
    int b0;
    do_reset();
    b0 = brk_total;
    rxd_i = 1'b0; tick(12 * 10);
`ifdef SIA_RX_BREAK_DETECT_EN
    checks++; if (brk_total - b0 != 1) begin errors++; $display("FAIL zero_break: got %0d expected 1", brk_total - b0); end
    checks++; if (rx_if.valid_o !== 1'b0) begin errors++; $display("FAIL zero_break_valid: got %b expected 0", rx_if.valid_o); end
    checks++; if (idle_o !== 1'b0) begin errors++; $display("FAIL zero_break_wait: got %b expected 0", idle_o); end
    rxd_i = 1'b1; tick(5);
    checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL zero_break_release: got %b expected 1", idle_o); end
`else
    checks++; if (rx_if.valid_o !== 1'b1) begin errors++; $display("FAIL zero_valid: got %b expected 1", rx_if.valid_o); end
    checks++; if (rx_if.dat_o !== exp_frame(64'd0, 11)) begin errors++; $display("FAIL zero_dat: got %h expected %h", rx_if.dat_o, exp_frame(64'd0, 11)); end
    checks++; if (brk_total - b0 != 0) begin errors++; $display("FAIL zero_no_break: got %0d expected 0", brk_total - b0); end
`endif
    rxd_i = 1'b1;
    do_reset();
  endtask

  task automatic test_bits_zero();
    int b0;
    do_reset();
    b0 = brk_total;
    bits_i = 6'd0; baud_i = 32'd9;
    rxd_i = 1'b0; tick(10); rxd_i = 1'b1; tick(30);
`ifdef SIA_RX_BREAK_DETECT_EN
    checks++; if (brk_total - b0 != 1) begin errors++; $display("FAIL bits0_break: got %0d expected 1", brk_total - b0); end
`else
    checks++; if (rx_if.dat_o !== exp_frame(64'd0, 0)) begin errors++; $display("FAIL bits0_dat: got %h expected %h", rx_if.dat_o, exp_frame(64'd0, 0)); end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_random_frames();
    test_external();
    test_overrun();
    test_full_push_pop();
    test_reset_midframe();
    test_zero_frame();
    test_bits_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
